// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the configurable UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame sequencer states; explicit 3-bit width so unused codes exist and
  // are steered back to IDLE by the sequencer.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Parity selection codes for the PARITY_MODE parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 25 MHz clock / 115200 bps.
  localparam int DEFAULT_CLOCKS_PER_BIT = 217;

  // Total clock cycles in one frame for a given configuration.
  function automatic int frame_cycles(input int cpb, input int dbits,
                                      input int pmode, input int sbits);
    return (1 + dbits + ((pmode != PAR_NONE) ? 1 : 0) + sbits) * cpb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg_if
// Purpose  : Valid/ready word handshake between a requester and the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] databus;
  logic                 valid;
  logic                 ready;

  // Requester side: offers words.
  modport master (output databus, output valid, input ready);

  // Transmitter side: accepts words.
  modport slave (input databus, input valid, output ready);

endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period counter; flags the last clock of every bit period.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic enable,
  output logic      bit_end
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..CLOCKS_PER_BIT-1 while enabled; hold at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bit_end = enable && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : Configurable UART transmitter (data bits, parity, stop bits).
//            Accepts a word on valid && ready and shifts it out LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = PAR_NONE,
  parameter int STOP_BITS      = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  uart_tx_cfg_if.slave  bus,
  output logic          outserial,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] C_LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP_BITS - 1);

  // Reject illegal configurations at elaboration.
  if ((CLOCKS_PER_BIT < 2) || (CLOCKS_PER_BIT > 65535)) begin : g_bad_cpb
    $error("uart_tx_cfg: CLOCKS_PER_BIT=%0d outside 2..65535", CLOCKS_PER_BIT);
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if ((PARITY_MODE != PAR_NONE) && (PARITY_MODE != PAR_EVEN) &&
      (PARITY_MODE != PAR_ODD)) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY_MODE=%0d is not 0, 1 or 2", PARITY_MODE);
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
  end

  uart_state_t          r_state;
  logic                 r_out;
  logic                 r_ready;
  logic                 r_par;
  logic [DATA_BITS-1:0] r_shift;
  logic [IW-1:0]        r_idx;
  logic                 w_bit_end;
  logic                 w_enable;

  // The bit-period counter only runs while a frame is on the line.
  assign w_enable = (r_state != IDLE);

  uart_baud_gen #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (w_enable),
    .bit_end (w_bit_end)
  );

  // Frame sequencer: latches the word, walks start/data/parity/stop bits and
  // drives the registered serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_out   <= 1'b1;
      r_ready <= 1'b1;
      r_par   <= 1'b0;
      r_shift <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out <= 1'b1;
          if (bus.valid) begin
            r_state <= START;
            r_out   <= 1'b0;
            r_ready <= 1'b0;
            r_shift <= bus.databus;
            // Parity is fixed at acceptance so later databus changes are moot.
            r_par   <= (^bus.databus) ^ (PARITY_MODE == PAR_ODD);
            r_idx   <= '0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_out   <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == C_LAST_DATA) begin
              r_idx <= '0;
              if (PARITY_MODE != PAR_NONE) begin
                r_state <= PARITY;
                r_out   <= r_par;
              end else begin
                r_state <= STOP;
                r_out   <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_shift <= r_shift >> 1;
              r_out   <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_out   <= 1'b1;
          end
        end
        STOP: begin
          r_out <= 1'b1;
          if (w_bit_end) begin
            if (r_idx == C_LAST_STOP) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_out   <= 1'b1;
          r_ready <= 1'b1;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign bus.ready = r_ready;
  assign busy      = ~r_ready;
  assign outserial = r_out;
  // Asserted in the final cycle of the last stop bit, i.e. the cycle whose
  // closing edge moves the sequencer back to IDLE.
  assign done      = (r_state == STOP) && w_bit_end && (r_idx == C_LAST_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Purpose  : Randomized self-checking bench for uart_tx_cfg in 8N1, 8E1 and
//            7O2 configurations against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Per-instance stimulus and observation, index 0: 8N1, 1: 8E1, 2: 7O2.
  logic [8:0] db [3];
  logic       vl [3];
  logic       rd [3];
  logic       os [3];
  logic       bz [3];
  logic       dn [3];

  int nb [3] = '{8, 8, 7};
  int pm [3] = '{0, 1, 2};
  int ns [3] = '{1, 1, 2};

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if2 ();

  assign if0.databus = db[0][7:0];
  assign if1.databus = db[1][7:0];
  assign if2.databus = db[2][6:0];
  assign if0.valid   = vl[0];
  assign if1.valid   = vl[1];
  assign if2.valid   = vl[2];
  assign rd[0]       = if0.ready;
  assign rd[1]       = if1.ready;
  assign rd[2]       = if2.ready;

  uart_tx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .outserial(os[0]), .busy(bz[0]), .done(dn[0]));
  uart_tx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .outserial(os[1]), .busy(bz[1]), .done(dn[1]));
  uart_tx_cfg #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .outserial(os[2]), .busy(bz[2]), .done(dn[2]));

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int k);
    return (1 + nb[k] + ((pm[k] != 0) ? 1 : 0) + ns[k]) * CPB;
  endfunction

  function automatic int data_mask(input int k);
    return (1 << nb[k]) - 1;
  endfunction

  // Reference line level for bit slot 'pos' of a frame carrying 'data'.
  function automatic int exp_bit(input int k, input int data, input int pos);
    int q[$];
    int ones;
    ones = 0;
    q.push_back(0);
    for (int b = 0; b < nb[k]; b++) begin
      q.push_back((data >> b) & 1);
      ones += (data >> b) & 1;
    end
    if (pm[k] == 1) q.push_back(ones % 2);
    if (pm[k] == 2) q.push_back(1 - (ones % 2));
    for (int s = 0; s < ns[k]; s++) q.push_back(1);
    return q[pos];
  endfunction

  // Called just after the accepting edge; checks every cycle of the frame.
  task automatic check_frame(input int k, input int data, input bit keep, input int next_db);
    int total;
    total = frame_len(k);
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      chk($sformatf("dut%0d data=%0h line cyc%0d", k, data, i), os[k], exp_bit(k, data, (i - 1) / CPB));
      chk($sformatf("dut%0d busy cyc%0d", k, i), bz[k], 1);
      chk($sformatf("dut%0d done cyc%0d", k, i), dn[k], (i == total) ? 1 : 0);
      if (i == 1) begin
        db[k] = keep ? 9'(next_db) : 9'($urandom);
        vl[k] = keep ? 1'b1 : 1'($urandom % 2);
      end else if (!keep) begin
        vl[k] = (i < total) ? 1'($urandom % 2) : 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int k);
    @(negedge clk);
    chk($sformatf("dut%0d idle line", k), os[k], 1);
    chk($sformatf("dut%0d idle ready", k), rd[k], 1);
    chk($sformatf("dut%0d idle done", k), dn[k], 0);
  endtask

  // Entered at a negedge; offers one word and checks the resulting frame.
  task automatic send(input int k, input int data);
    int w;
    w = 0;
    while (rd[k] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("dut%0d ready before send", k), rd[k], 1);
    db[k] = 9'(data);
    vl[k] = 1'b1;
    @(posedge clk);
    check_frame(k, data, 1'b0, 0);
    idle_check(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      db[k] = '0;
      vl[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d reset line", k), os[k], 1);
      chk($sformatf("dut%0d reset ready", k), rd[k], 1);
      chk($sformatf("dut%0d reset busy", k), bz[k], 0);
      chk($sformatf("dut%0d reset done", k), dn[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames from the known-answer cases.
    send(0, 'hA5);
    send(1, 'h07);
    send(2, 'h55);

    // Random words on every configuration.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 3; k++) begin
        send(k, int'($urandom) & data_mask(k));
      end
    end

    // valid held high: 0x01 then 0x80 with exactly one idle cycle between.
    db[0] = 9'h001;
    vl[0] = 1'b1;
    @(posedge clk);
    check_frame(0, 'h01, 1'b1, 'h80);
    @(negedge clk);
    chk("b2b gap line", os[0], 1);
    chk("b2b gap ready", rd[0], 1);
    @(posedge clk);
    check_frame(0, 'h80, 1'b0, 0);
    idle_check(0);

    // Reset asserted in cycle 13 of an 8N1 frame.
    db[0] = 9'($urandom);
    vl[0] = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      vl[0] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst line", os[0], 1);
    chk("midrst ready", rd[0], 1);
    chk("midrst busy", bz[0], 0);
    chk("midrst done", dn[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("post-rst done cyc%0d", i), dn[0], 0);
      chk($sformatf("post-rst line cyc%0d", i), os[0], 1);
    end
    send(0, 'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
